// File: rtl/fp_pkg.sv
// Shared types and constants for the 12-bit sample to 8-bit float converter.
package fp_pkg;

  localparam int IN_W_DEF  = 12;
  localparam int EXP_W_DEF = 3;
  localparam int SIG_W_DEF = 4;

  localparam logic [2:0] E_MAX   = 3'd7;
  localparam logic [3:0] SIG_MAX = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ABS   = 3'd1,
    ST_NORM  = 3'd2,
    ST_ROUND = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic       sign;
    logic [2:0] exp;
    logic [3:0] sig;
  } float8_t;

endpackage

// File: rtl/fp_convert_sequencer_twoCompToSignMag.sv
// Two's-complement to sign/magnitude. The most negative code has no positive
// twin, so its magnitude saturates to the largest positive value.
module twoCompToSignMag #(
  parameter int W = 12
) (
  input  logic [W-1:0] i_data,
  output logic         o_sign,
  output logic [W-1:0] o_mag
);

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_POS  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

  // Sign is the msb; magnitude negates negative codes, clamping the most negative.
  always_comb begin
    o_sign = i_data[W-1];
    if (i_data == MOST_NEG) begin
      o_mag = MAX_POS;
    end else if (i_data[W-1]) begin
      o_mag = ~i_data + ONE;
    end else begin
      o_mag = i_data;
    end
  end

endmodule

// File: rtl/fp_convert_sequencer.sv
// Multi-cycle sample-to-float converter: abs value, normalise one bit per
// cycle, round half up, then hold the result until the consumer takes it.
//
// state  | meaning
// IDLE   | in_ready high, waiting for in_valid
// ABS    | register sign and magnitude of the captured sample
// NORM   | shift magnitude left / decrement exponent until msb set or e==0
// ROUND  | round to SIG_W bits, handle carry-out and saturation
// DONE   | first cycle raises out_valid, then hold until out_ready
module fp_convert_sequencer
  import fp_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int EXP_W = EXP_W_DEF,
  parameter int SIG_W = SIG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [SIG_W-1:0] out_sig,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sat,
  output logic             busy
);

  // Magnitude never uses bit IN_W-1, so the normalised leading one sits at IN_W-2.
  localparam int MSB_POS = IN_W - 2;
  localparam int RND_POS = MSB_POS - SIG_W;

  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [EXP_W-1:0] EXP_TOP = {EXP_W{1'b1}};
  localparam logic [SIG_W-1:0] SIG_HALF = {1'b1, {(SIG_W-1){1'b0}}};
  localparam logic [SIG_W-1:0] SIG_TOP  = {SIG_W{1'b1}};

  state_t            r_state;
  logic [IN_W-1:0]   r_data;
  logic              r_sign;
  logic [IN_W-1:0]   r_m;
  logic [EXP_W-1:0]  r_e;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_out_valid;
  logic              r_out_sign;
  logic [EXP_W-1:0]  r_out_exp;
  logic [SIG_W-1:0]  r_out_sig;
  logic              r_out_sat;

  logic              w_abs_sign;
  logic [IN_W-1:0]   w_abs_mag;
  logic [SIG_W-1:0]  w_frac;
  logic              w_rbit;
  logic [SIG_W:0]    w_sum;
  logic              w_carry;
  logic              w_norm_done;

  twoCompToSignMag #(
    .W (IN_W)
  ) u_abs (
    .i_data (r_data),
    .o_sign (w_abs_sign),
    .o_mag  (w_abs_mag)
  );

  // Rounding datapath on the normalised magnitude.
  always_comb begin
    w_frac      = r_m[MSB_POS -: SIG_W];
    w_rbit      = r_m[RND_POS];
    w_sum       = {1'b0, w_frac} + {{SIG_W{1'b0}}, w_rbit};
    w_carry     = w_sum[SIG_W];
    w_norm_done = r_m[MSB_POS] || (r_e == '0);
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_data      <= '0;
      r_sign      <= 1'b0;
      r_m         <= '0;
      r_e         <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sign  <= 1'b0;
      r_out_exp   <= '0;
      r_out_sig   <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_data     <= in_data;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_ABS;
          end
        end
        ST_ABS: begin
          r_sign  <= w_abs_sign;
          r_m     <= w_abs_mag;
          r_e     <= EXP_TOP;
          r_state <= ST_NORM;
        end
        ST_NORM: begin
          if (w_norm_done) begin
            r_state <= ST_ROUND;
          end else begin
            r_m <= r_m << 1;
            r_e <= r_e - EXP_ONE;
          end
        end
        ST_ROUND: begin
          r_out_sign <= r_sign;
          if (!w_carry) begin
            r_out_sig <= w_sum[SIG_W-1:0];
            r_out_exp <= r_e;
            r_out_sat <= 1'b0;
          end else if (r_e != EXP_TOP) begin
            r_out_sig <= SIG_HALF;
            r_out_exp <= r_e + EXP_ONE;
            r_out_sat <= 1'b0;
          end else begin
            r_out_sig <= SIG_TOP;
            r_out_exp <= EXP_TOP;
            r_out_sat <= 1'b1;
          end
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          // out_ready only counts once out_valid is actually visible.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_sign  = r_out_sign;
  assign out_exp   = r_out_exp;
  assign out_sig   = r_out_sig;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_fp_convert_sequencer.sv
// Directed bench for fp_convert_sequencer with hand-computed float results.
module tb_fp_convert_sequencer;
  import fp_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [11:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        out_sign;
  logic [2:0]  out_exp;
  logic [3:0]  out_sig;
  logic        out_valid;
  logic        out_ready;
  logic        out_sat;
  logic        busy;

  int errors;
  int checks;

  fp_convert_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_sig   (out_sig),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] result();
    float8_t f;
    f = '{sign: out_sign, exp: out_exp, sig: out_sig};
    return f;
  endfunction

  // Counts edges after the accept edge until out_valid is seen, capped at 30.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic accept(input logic [11:0] d, input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Full conversion with out_ready already high.
  task automatic convert(input logic [11:0] d, input logic [7:0] exp_f,
                         input logic exp_sat, input int exp_lat, input string tag);
    int lat;
    accept(d, tag);
    wait_valid(lat);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_result"}, result(), exp_f);
    chk({tag, "_sat"}, out_sat, exp_sat);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_in_ready_busy"}, in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk({tag, "_valid_drop"}, out_valid, 1'b0);
    chk({tag, "_back_idle"}, in_ready, 1'b1);
  endtask

  initial begin
    int lat;
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result(), 8'h00);
    chk("rst_sat", out_sat, 1'b0);
    rst_n = 1'b1;

    convert(12'd422,  8'h5D, 1'b0, 6,  "pos422");
    convert(12'hE5A,  8'hDD, 1'b0, 6,  "neg422");
    convert(12'd125,  8'h48, 1'b0, 8,  "carry125");
    convert(12'h800,  8'hFF, 1'b1, 4,  "most_neg");
    convert(12'd2047, 8'h7F, 1'b1, 4,  "max_pos");
    convert(12'd0,    8'h00, 1'b0, 11, "zero");
    convert(12'd5,    8'h05, 1'b0, 11, "e_floor");

    // Backpressure: result must hold and new samples must be ignored.
    out_ready = 1'b0;
    accept(12'd422, "bp");
    wait_valid(lat);
    chk("bp_latency", lat, 6);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 12'd2047;
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_result", result(), 8'h5D);
      chk("bp_hold_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", in_ready, 1'b1);
    chk("bp_release_valid", out_valid, 1'b0);
    chk("bp_release_hold", result(), 8'h5D);
    convert(12'd125, 8'h48, 1'b0, 8, "bp_next");

    // Reset while normalising discards the conversion.
    accept(12'd5, "mid_rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_result", result(), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat++;
    end
    chk("mid_rst_no_valid", lat, 0);
    convert(12'h800, 8'hFF, 1'b1, 4, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
